// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: FSM states, strobe kinds, R/W bit values and glitch-filter depth for the I2C target.
package i2c_target_pkg;
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  typedef enum logic [1:0] {STB_NONE, STB_ADDR, STB_WR, STB_RD} stb_t;
  localparam logic I2C_WRITE  = 1'b0;
  localparam logic I2C_READ   = 1'b1;
  localparam int   FILT_DEPTH = 3;
endpackage

// File: rtl/i2c_bus_cond_det.sv
// i2c_bus_cond_det: synchronizes SCL/SDA and flags SCL edges plus START/STOP.
// Defining I2C_GLITCH_FILTER_EN adds a FILT_DEPTH-sample stability filter after the synchronizers.
module i2c_bus_cond_det
  import i2c_target_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl, scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
`ifdef I2C_GLITCH_FILTER_EN
  logic [FILT_DEPTH-2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic [FILT_DEPTH-1:0] scl_win, sda_win;
  logic                  scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  // Output only moves once the whole window agrees, so short pulses never reach it.
  always_comb begin
    scl_win    = {scl_hist_q, scl_sync_q[1]};
    sda_win    = {sda_hist_q, sda_sync_q[1]};
    scl_hist_d = scl_win[FILT_DEPTH-2:0];
    sda_hist_d = sda_win[FILT_DEPTH-2:0];
    scl_filt_d = &scl_win ? 1'b1 : ~|scl_win ? 1'b0 : scl_filt_q;
    sda_filt_d = &sda_win ? 1'b1 : ~|sda_win ? 1'b0 : sda_filt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end
  assign scl = scl_filt_q;
  assign sda = sda_filt_q;
`else
  assign scl = scl_sync_q[1];
  assign sda = sda_sync_q[1];
`endif
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl;
    sda_prev_d = sda;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end
  assign scl_rise = scl & ~scl_prev_q;
  assign scl_fall = ~scl & scl_prev_q;
  assign start    = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop     = scl & scl_prev_q & ~sda_prev_q & sda;
endmodule

// File: rtl/i2c_target_reg_if.sv
// i2c_target_reg_if: I2C target front-end; strobes pointer, write and read events to a host register model.
// Define I2C_GLITCH_FILTER_EN to enable the SCL/SDA glitch filter in i2c_bus_cond_det.
module i2c_target_reg_if
  import i2c_target_pkg::*;
#(
  parameter logic [7:0] device_address = 8'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       scl_io,
  inout  logic       sda_io,
  output logic       addr_strobe,
  output logic       write_strobe,
  output logic       read_strobe,
  output logic [7:0] wdata,
  input  logic [7:0] rdata
);
  logic   sda, scl_rise, scl_fall, start, stop;
  state_t state_q, state_d;
  stb_t   pend_q, pend_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, wdata_q, wdata_d;
  logic oe_q, oe_d, rw_q, rw_d, ptr_seen_q, ptr_seen_d;
  logic addr_stb_q, addr_stb_d, wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;

  i2c_bus_cond_det u_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_io),
    .sda_in   (sda_io),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    wdata_d    = wdata_q;
    oe_d       = oe_q;
    rw_d       = rw_q;
    ptr_seen_d = ptr_seen_q;
    pend_d     = STB_NONE;
    addr_stb_d = pend_q == STB_ADDR;
    wr_stb_d   = pend_q == STB_WR;
    rd_stb_d   = pend_q == STB_RD;
    if (stop) begin
      state_d    = IDLE;
      oe_d       = 1'b0;
      ptr_seen_d = 1'b0;
    end else if (start) begin
      state_d = enable ? DEV_ADDR : WAIT_STOP;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rw_d    = sda ? I2C_READ : I2C_WRITE;
            state_d = (enable && shift_q[6:0] == device_address[7:1]) ? DEV_ACK : WAIT_STOP;
          end
        end
        // First fall after the 8th bit starts the ACK, the second one ends it.
        DEV_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            cnt_d   = 4'd0;
            state_d = (rw_q == I2C_WRITE) ? (ptr_seen_q ? WR_DATA : PTR) : RD_DATA;
            shift_d = rdata;
            oe_d    = (rw_q == I2C_READ) & ~rdata[7];
          end
        end
        PTR, WR_DATA: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            wdata_d    = {shift_q[6:0], sda};
            pend_d     = (state_q == PTR) ? STB_ADDR : STB_WR;
            state_d    = (state_q == PTR) ? PTR_ACK : WR_ACK;
            ptr_seen_d = 1'b1;
          end
        end
        PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!oe_q) oe_d = 1'b1;
          else begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = RD_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            pend_d = STB_RD;
            if (sda) state_d = WAIT_STOP;
          end
          if (scl_fall) begin
            shift_d = rdata;
            oe_d    = ~rdata[7];
            cnt_d   = 4'd0;
            state_d = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= STB_NONE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      wdata_q    <= 8'h00;
      oe_q       <= 1'b0;
      rw_q       <= I2C_WRITE;
      ptr_seen_q <= 1'b0;
      addr_stb_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      ptr_seen_q <= ptr_seen_d;
      addr_stb_q <= addr_stb_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
    end
  end

  assign sda_io       = oe_q ? 1'b0 : 1'bz;
  assign addr_strobe  = addr_stb_q;
  assign write_strobe = wr_stb_q;
  assign read_strobe  = rd_stb_q;
  assign wdata        = wdata_q;
endmodule

// File: tb/tb_i2c_target_reg_if.sv
// tb_i2c_target_reg_if: directed I2C master transactions against i2c_target_reg_if with strobe monitoring.
module tb_i2c_target_reg_if;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, m_scl = 1'b1, m_sda_low = 1'b0;
  logic [7:0] rdata = 8'h00;
  logic addr_strobe, write_strobe, read_strobe;
  logic [7:0] wdata;
  wire sda_bus;
  int n_tests = 0, n_fail = 0;
  int addr_cnt = 0, wr_cnt = 0, rd_cnt = 0, multi_cnt = 0, unstable_cnt = 0;
  int a0, w0, r0;
  logic [7:0] addr_val = 8'h00, wdata_prev = 8'h00, rx;
  logic [7:0] wr_log [16];
  logic ack;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  always #5 clk = ~clk;

  i2c_target_reg_if #(.device_address(8'h42)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .scl_io       (m_scl),
    .sda_io       (sda_bus),
    .addr_strobe  (addr_strobe),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .wdata        (wdata),
    .rdata        (rdata)
  );

  always @(negedge clk) begin
    if ((addr_strobe & write_strobe) | (addr_strobe & read_strobe) | (write_strobe & read_strobe))
      multi_cnt++;
    if ((addr_strobe | write_strobe) && wdata !== wdata_prev) unstable_cnt++;
    if (addr_strobe) begin addr_cnt++; addr_val = wdata; end
    if (write_strobe) begin
      if (wr_cnt < 16) wr_log[wr_cnt] = wdata;
      wr_cnt++;
    end
    if (read_strobe) rd_cnt++;
    wdata_prev = wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; q(); m_scl = 1'b1; q(); m_sda_low = 1'b1; q(); m_scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; q(); m_scl = 1'b1; q(); m_sda_low = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
    end
    m_sda_low = 1'b0; q(); m_scl = 1'b1; q();
    a = sda_bus;
    q(); m_scl = 1'b0; q();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    b = 8'h00;
    m_sda_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q(); m_scl = 1'b1; q();
      b = {b[6:0], sda_bus};
      q(); m_scl = 1'b0;
    end
    q(); m_sda_low = ~nack; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
    m_sda_low = 1'b0;
  endtask

  initial begin
    q();
    check("rst_wdata", wdata, 8'h00);
    check("rst_strobes", {addr_strobe, write_strobe, read_strobe}, 3'b000);
    check("rst_sda", sda_bus, 1'b1);
    rst_n = 1'b1; q();

    a0 = addr_cnt; w0 = wr_cnt;
    i2c_start();
    send_byte(8'h42, ack); check("t1_ack_dev", ack, 1'b0);
    send_byte(8'h01, ack); check("t1_ack_ptr", ack, 1'b0);
    send_byte(8'hA5, ack); check("t1_ack_wr", ack, 1'b0);
    i2c_stop(); q();
    check("t1_addr_cnt", addr_cnt - a0, 1);
    check("t1_addr_val", addr_val, 8'h01);
    check("t1_wr_cnt", wr_cnt - w0, 1);
    check("t1_wr_val", wr_log[w0], 8'hA5);
    check("t1_wdata_hold", wdata, 8'hA5);
    check("t1_sda_idle", sda_bus, 1'b1);

    a0 = addr_cnt; w0 = wr_cnt;
    i2c_start();
    send_byte(8'h42, ack);
    send_byte(8'h01, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    send_byte(8'h33, ack); check("t2_ack_last", ack, 1'b0);
    i2c_stop(); q();
    check("t2_addr_cnt", addr_cnt - a0, 1);
    check("t2_wr_cnt", wr_cnt - w0, 3);
    check("t2_wr0", wr_log[w0], 8'h11);
    check("t2_wr1", wr_log[w0+1], 8'h22);
    check("t2_wr2", wr_log[w0+2], 8'h33);

    a0 = addr_cnt; w0 = wr_cnt; r0 = rd_cnt;
    rdata = 8'h5A;
    i2c_start();
    send_byte(8'h42, ack);
    send_byte(8'h00, ack); check("t3_ack_ptr", ack, 1'b0);
    i2c_start();
    send_byte(8'h43, ack); check("t3_ack_rd_addr", ack, 1'b0);
    recv_byte(1'b1, rx);
    check("t3_rx_byte", rx, 8'h5A);
    check("t3_rd_cnt", rd_cnt - r0, 1);
    q(); m_scl = 1'b1; q();
    check("t3_wait_stop_sda", sda_bus, 1'b1);
    q(); m_scl = 1'b0; q();
    i2c_stop(); q();
    check("t3_rd_cnt_after", rd_cnt - r0, 1);
    check("t3_addr_val", addr_val, 8'h00);
    check("t3_wr_cnt", wr_cnt - w0, 0);

    a0 = addr_cnt; w0 = wr_cnt; r0 = rd_cnt;
    i2c_start();
    send_byte(8'h44, ack); check("t4_nack_mismatch", ack, 1'b1);
    send_byte(8'h55, ack); check("t4_nack_follow", ack, 1'b1);
    i2c_stop(); q();
    enable = 1'b0;
    i2c_start();
    send_byte(8'h42, ack); check("t4_nack_disabled", ack, 1'b1);
    send_byte(8'h66, ack);
    i2c_stop(); q();
    check("t4_no_strobes", (addr_cnt - a0) + (wr_cnt - w0) + (rd_cnt - r0), 0);
    enable = 1'b1;
    i2c_start();
    send_byte(8'h42, ack); check("t4_ack_recover", ack, 1'b0);
    send_byte(8'h07, ack);
    send_byte(8'h99, ack);
    i2c_stop(); q();
    check("t4_addr_val", addr_val, 8'h07);
    check("t4_wdata", wdata, 8'h99);

    rdata = 8'h00;
    r0 = rd_cnt;
    i2c_start();
    send_byte(8'h42, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'h43, ack);
    m_sda_low = 1'b0; q(); m_scl = 1'b1; q();
    check("t5_rd_driving", sda_bus, 1'b0);
    rst_n = 1'b0; #1;
    check("t5_rst_sda", sda_bus, 1'b1);
    check("t5_rst_wdata", wdata, 8'h00);
    check("t5_rst_strobes", {addr_strobe, write_strobe, read_strobe}, 3'b000);
    q(); m_scl = 1'b0; q(); rst_n = 1'b1; q();
    check("t5_rd_cnt", rd_cnt - r0, 0);
    a0 = addr_cnt; w0 = wr_cnt;
    i2c_start();
    send_byte(8'h42, ack); check("t5_ack_dev", ack, 1'b0);
    send_byte(8'h10, ack); check("t5_ack_ptr", ack, 1'b0);
    send_byte(8'h77, ack); check("t5_ack_wr", ack, 1'b0);
    i2c_stop(); q();
    check("t5_addr_val", addr_val, 8'h10);
    check("t5_wr_cnt", wr_cnt - w0, 1);
    check("t5_wr_val", wr_log[w0], 8'h77);

`ifdef I2C_GLITCH_FILTER_EN
    a0 = addr_cnt; w0 = wr_cnt;
    m_sda_low = 1'b1; @(posedge clk); #1; m_sda_low = 1'b0;
    q(); q();
    m_scl = 1'b0; q();
    send_byte(8'h42, ack); check("t6_glitch_no_start", ack, 1'b1);
    send_byte(8'h05, ack); check("t6_glitch_no_ptr", ack, 1'b1);
    i2c_stop(); q();
    check("t6_no_strobes", (addr_cnt - a0) + (wr_cnt - w0), 0);
`endif

    check("one_strobe_per_clk", multi_cnt, 0);
    check("wdata_stable_at_strobe", unstable_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
